// File: rtl/laser_pkg.sv
// Shared types and constants for the two-circle laser sweep sequencer.
// Grid coordinates, FSM states, pass selector and raster step helper.
package laser_pkg;

  localparam int N_PTS = 40;
  localparam int BATCH = 4;
  localparam logic [3:0] GRID_MAX = 4'd15;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_CALC,
    S_UPDATE,
    S_CHECK,
    S_FINISH
  } state_e;

  typedef enum logic {
    PASS_C1,
    PASS_C2
  } pass_e;

  typedef struct packed {
    logic [3:0] x;
    logic [3:0] y;
  } pt_t;

  // X runs fastest; (15,15) wraps to (0,0).
  function automatic pt_t raster_next(pt_t p);
    pt_t n;
    n.x = (p.x == GRID_MAX) ? 4'd0 : p.x + 4'd1;
    n.y = (p.x == GRID_MAX) ? p.y + 4'd1 : p.y;
    return n;
  endfunction

endpackage

// File: rtl/laser_best_tracker.sv
// Per-candidate hit accumulator and best-count register.
// take is asserted when the current candidate ties or beats the best.
module laser_best_tracker (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       add_en,
  input  logic       upd_en,
  input  logic [2:0] hit,
  output logic       take
);

  logic [5:0] acc_q, acc_d;
  logic [5:0] best_q, best_d;

  // later candidates win ties, so >= rather than >
  assign take = (acc_q >= best_q);

  // clear at pass start, accumulate per batch, capture at candidate end
  always_comb begin
    acc_d  = acc_q;
    best_d = best_q;
    unique case (1'b1)
      clr: begin
        acc_d  = '0;
        best_d = '0;
      end
      add_en: acc_d = acc_q + {3'b000, hit};
      upd_en: begin
        if (take) best_d = acc_q;
        acc_d = '0;
      end
      default: ;
    endcase
  end

  // accumulator and best-count registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      best_q <= '0;
    end else begin
      acc_q  <= acc_d;
      best_q <= best_d;
    end
  end

endmodule

// File: rtl/laser_sweep_ctrl.sv
// Sequencer for the two-circle coverage search: rasters candidates,
// keeps best C1/C2 and alternates passes until convergence or cap.
module laser_sweep_ctrl #(
  parameter int N_PTS    = laser_pkg::N_PTS,
  parameter int BATCH    = laser_pkg::BATCH,
  parameter int MAX_ITER = 8
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       START,
  input  logic [2:0] HIT_CNT,
  output logic [3:0] SCAN_X,
  output logic [3:0] SCAN_Y,
  output logic [3:0] FIX_X,
  output logic [3:0] FIX_Y,
  output logic [5:0] PT_ADDR,
  output logic       CALC,
  output logic [3:0] C1X,
  output logic [3:0] C1Y,
  output logic [3:0] C2X,
  output logic [3:0] C2Y,
  output logic [3:0] ITER,
  output logic       BUSY,
  output logic       DONE
);

  import laser_pkg::*;

  localparam logic [5:0] LAST_ADDR = 6'(N_PTS - BATCH);
  localparam logic [5:0] STEP      = 6'(BATCH);
  localparam logic [3:0] LAST_ITER = 4'(MAX_ITER - 1);
  localparam pt_t        CORNER    = '{x: GRID_MAX, y: GRID_MAX};

  state_e     state_q, state_d;
  pass_e      pass_q, pass_d;
  pt_t        scan_q, scan_d;
  logic [5:0] addr_q, addr_d;
  logic [3:0] iter_q, iter_d;
  pt_t        best_c1_q, best_c1_d;
  pt_t        best_c2_q, best_c2_d;
  pt_t        snap_c1_q, snap_c1_d;
  pt_t        snap_c2_q, snap_c2_d;
  pt_t        res_c1_q, res_c1_d;
  pt_t        res_c2_q, res_c2_d;
  logic       calc_q, calc_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       take;

  laser_best_tracker u_tracker (
    .clk    (CLK),
    .rst_n  (RST_N),
    .clr    (state_q == S_INIT),
    .add_en (state_q == S_CALC),
    .upd_en (state_q == S_UPDATE),
    .hit    (HIT_CNT),
    .take   (take)
  );

  assign SCAN_X  = scan_q.x;
  assign SCAN_Y  = scan_q.y;
  assign FIX_X   = (pass_q == PASS_C1) ? best_c2_q.x : best_c1_q.x;
  assign FIX_Y   = (pass_q == PASS_C1) ? best_c2_q.y : best_c1_q.y;
  assign PT_ADDR = addr_q;
  assign CALC    = calc_q;
  assign C1X     = res_c1_q.x;
  assign C1Y     = res_c1_q.y;
  assign C2X     = res_c2_q.x;
  assign C2Y     = res_c2_q.y;
  assign ITER    = iter_q;
  assign BUSY    = busy_q;
  assign DONE    = done_q;

  // next-state, counters and best/snapshot/result capture
  always_comb begin
    state_d   = state_q;
    pass_d    = pass_q;
    scan_d    = scan_q;
    addr_d    = addr_q;
    iter_d    = iter_q;
    best_c1_d = best_c1_q;
    best_c2_d = best_c2_q;
    snap_c1_d = snap_c1_q;
    snap_c2_d = snap_c2_q;
    res_c1_d  = res_c1_q;
    res_c2_d  = res_c2_q;
    unique case (state_q)
      S_IDLE: begin
        if (START) begin
          best_c1_d = '0;
          best_c2_d = '0;
          iter_d    = '0;
          pass_d    = PASS_C1;
          state_d   = S_INIT;
        end
      end
      S_INIT: begin
        scan_d = '0;
        addr_d = '0;
        if (pass_q == PASS_C1) begin
          snap_c1_d = best_c1_q;
          snap_c2_d = best_c2_q;
        end
        state_d = S_CALC;
      end
      S_CALC: begin
        if (addr_q == LAST_ADDR) begin
          addr_d  = '0;
          state_d = S_UPDATE;
        end else begin
          addr_d = addr_q + STEP;
        end
      end
      S_UPDATE: begin
        if (take) begin
          if (pass_q == PASS_C1) best_c1_d = scan_q;
          else                   best_c2_d = scan_q;
        end
        addr_d = '0;
        scan_d = raster_next(scan_q);
        if (scan_q == CORNER) begin
          if (pass_q == PASS_C1) begin
            pass_d  = PASS_C2;
            state_d = S_INIT;
          end else begin
            state_d = S_CHECK;
          end
        end else begin
          state_d = S_CALC;
        end
      end
      S_CHECK: begin
        if ((best_c1_q == snap_c1_q && best_c2_q == snap_c2_q)
            || iter_q == LAST_ITER) begin
          state_d = S_FINISH;
        end else begin
          iter_d  = iter_q + 4'd1;
          pass_d  = PASS_C1;
          state_d = S_INIT;
        end
      end
      S_FINISH: begin
        res_c1_d = best_c1_q;
        res_c2_d = best_c2_q;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign calc_d = (state_d == S_CALC);
  assign busy_d = (state_d != S_IDLE);
  assign done_d = (state_d == S_FINISH);

  // all sequencer state and registered outputs
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= S_IDLE;
      pass_q    <= PASS_C1;
      scan_q    <= '0;
      addr_q    <= '0;
      iter_q    <= '0;
      best_c1_q <= '0;
      best_c2_q <= '0;
      snap_c1_q <= '0;
      snap_c2_q <= '0;
      res_c1_q  <= '0;
      res_c2_q  <= '0;
      calc_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pass_q    <= pass_d;
      scan_q    <= scan_d;
      addr_q    <= addr_d;
      iter_q    <= iter_d;
      best_c1_q <= best_c1_d;
      best_c2_q <= best_c2_d;
      snap_c1_q <= snap_c1_d;
      snap_c2_q <= snap_c2_d;
      res_c1_q  <= res_c1_d;
      res_c2_q  <= res_c2_d;
      calc_q    <= calc_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

endmodule

// File: tb/tb_laser_sweep_ctrl.sv
// Directed bench for laser_sweep_ctrl with a behavioural hit model.
// Second instance runs with MAX_ITER=1 alongside the first frame.
module tb_laser_sweep_ctrl;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic       start_a, start_b;
  logic [2:0] hit_a, hit_b;
  logic [3:0] a_sx, a_sy, a_fx, a_fy, a_c1x, a_c1y, a_c2x, a_c2y, a_it;
  logic [3:0] b_sx, b_sy, b_fx, b_fy, b_c1x, b_c1y, b_c2x, b_c2y, b_it;
  logic [5:0] a_addr, b_addr;
  logic       a_calc, a_busy, a_done, b_calc, b_busy, b_done;

  int px [40];
  int py [40];
  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  laser_sweep_ctrl dut_a (
    .CLK(CLK), .RST_N(RST_N), .START(start_a), .HIT_CNT(hit_a),
    .SCAN_X(a_sx), .SCAN_Y(a_sy), .FIX_X(a_fx), .FIX_Y(a_fy),
    .PT_ADDR(a_addr), .CALC(a_calc),
    .C1X(a_c1x), .C1Y(a_c1y), .C2X(a_c2x), .C2Y(a_c2y),
    .ITER(a_it), .BUSY(a_busy), .DONE(a_done)
  );

  laser_sweep_ctrl #(.MAX_ITER(1)) dut_b (
    .CLK(CLK), .RST_N(RST_N), .START(start_b), .HIT_CNT(hit_b),
    .SCAN_X(b_sx), .SCAN_Y(b_sy), .FIX_X(b_fx), .FIX_Y(b_fy),
    .PT_ADDR(b_addr), .CALC(b_calc),
    .C1X(b_c1x), .C1Y(b_c1y), .C2X(b_c2x), .C2Y(b_c2y),
    .ITER(b_it), .BUSY(b_busy), .DONE(b_done)
  );

  function automatic bit covers(int x, int y, int cx, int cy);
    int dx;
    int dy;
    dx = (x > cx) ? x - cx : cx - x;
    dy = (y > cy) ? y - cy : cy - y;
    return (dx + dy <= 4) || (dx == 2 && dy == 3) || (dx == 3 && dy == 2);
  endfunction

  function automatic logic [2:0] batch_hits(logic [5:0] a, logic [3:0] sx,
      logic [3:0] sy, logic [3:0] fx, logic [3:0] fy);
    int n;
    int k;
    n = 0;
    for (int i = 0; i < 4; i++) begin
      k = int'(a) + i;
      if (k < 40)
        if (covers(px[k], py[k], int'(sx), int'(sy)) ||
            covers(px[k], py[k], int'(fx), int'(fy)))
          n++;
    end
    return 3'(n);
  endfunction

  assign hit_a = batch_hits(a_addr, a_sx, a_sy, a_fx, a_fy);
  assign hit_b = batch_hits(b_addr, b_sx, b_sy, b_fx, b_fy);

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  // protocol monitor on dut_a: CALC bursts of 10 with PT_ADDR 0..36
  bit mon_en = 1'b0;
  int run = 0;
  int proto_err = 0;
  int cand_cnt = 0;
  always @(negedge CLK) begin
    if (mon_en) begin
      if (a_calc) begin
        if (int'(a_addr) != 4 * run) proto_err++;
        run++;
      end else if (run != 0) begin
        if (run != 10) proto_err++;
        cand_cnt++;
        run = 0;
      end
    end
  end

  typedef struct {
    int cyc;
    int sx, sy, fx, fy, addr, calc, iter, busy, done;
  } vec_t;

  vec_t tbl [14];

  initial begin
    int ti;
    int da_cyc, db_cyc, da_n, db_n, bad;
    tbl[0]  = '{1,     0,  0,  0,  0,  0, 0, 0, 1, 0};
    tbl[1]  = '{2,     0,  0,  0,  0,  0, 1, 0, 1, 0};
    tbl[2]  = '{11,    0,  0,  0,  0, 36, 1, 0, 1, 0};
    tbl[3]  = '{12,    0,  0,  0,  0,  0, 0, 0, 1, 0};
    tbl[4]  = '{13,    1,  0,  0,  0,  0, 1, 0, 1, 0};
    tbl[5]  = '{190,   1,  1,  0,  0,  4, 1, 0, 1, 0};
    tbl[6]  = '{2817, 15, 15,  0,  0,  0, 0, 0, 1, 0};
    tbl[7]  = '{2818,  0,  0,  5,  9,  0, 0, 0, 1, 0};
    tbl[8]  = '{2820,  0,  0,  5,  9,  4, 1, 0, 1, 0};
    tbl[9]  = '{5635,  0,  0,  5,  9,  0, 0, 0, 1, 0};
    tbl[10] = '{5636,  0,  0, 15, 15,  0, 0, 1, 1, 0};
    tbl[11] = '{11270, 0,  0,  5,  9,  0, 0, 1, 1, 0};
    tbl[12] = '{11271, 0,  0,  5,  9,  0, 0, 1, 1, 1};
    tbl[13] = '{11272, 0,  0,  5,  9,  0, 0, 1, 0, 0};

    RST_N = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    for (int i = 0; i < 40; i++) begin px[i] = 5; py[i] = 5; end
    repeat (2) @(negedge CLK);
    chk("rst_busy", int'(a_busy), 0);
    chk("rst_done", int'(a_done), 0);
    chk("rst_calc", int'(a_calc), 0);
    chk("rst_iter", int'(a_it), 0);
    chk("rst_scan", int'({a_sx, a_sy}), 0);
    chk("rst_fix", int'({a_fx, a_fy}), 0);
    chk("rst_res", int'({a_c1x, a_c1y, a_c2x, a_c2y}), 0);
    RST_N = 1'b1;
    @(negedge CLK);

    // frame A: all points at (5,5), both instances
    start_a = 1'b1;
    start_b = 1'b1;
    @(posedge CLK);
    mon_en = 1'b1;
    ti = 0; da_cyc = -1; db_cyc = -1; da_n = 0; db_n = 0;
    for (int cyc = 1; cyc <= 11290; cyc++) begin
      @(negedge CLK);
      if (cyc == 1) begin start_a = 1'b0; start_b = 1'b0; end
      if (ti < 14 && tbl[ti].cyc == cyc) begin
        chk($sformatf("v%0d_scan_x", ti), int'(a_sx), tbl[ti].sx);
        chk($sformatf("v%0d_scan_y", ti), int'(a_sy), tbl[ti].sy);
        chk($sformatf("v%0d_fix_x", ti), int'(a_fx), tbl[ti].fx);
        chk($sformatf("v%0d_fix_y", ti), int'(a_fy), tbl[ti].fy);
        chk($sformatf("v%0d_pt_addr", ti), int'(a_addr), tbl[ti].addr);
        chk($sformatf("v%0d_calc", ti), int'(a_calc), tbl[ti].calc);
        chk($sformatf("v%0d_iter", ti), int'(a_it), tbl[ti].iter);
        chk($sformatf("v%0d_busy", ti), int'(a_busy), tbl[ti].busy);
        chk($sformatf("v%0d_done", ti), int'(a_done), tbl[ti].done);
        ti++;
      end
      if (a_done) begin da_n++; if (da_cyc < 0) da_cyc = cyc; end
      if (b_done) begin db_n++; if (db_cyc < 0) db_cyc = cyc; end
    end
    mon_en = 1'b0;
    chk("a_vectors_reached", ti, 14);
    chk("a_done_cycle", da_cyc, 11271);
    chk("a_done_count", da_n, 1);
    chk("a_c1", int'({a_c1x, a_c1y}), 8'h59);
    chk("a_c2", int'({a_c2x, a_c2y}), 8'hff);
    chk("a_iter", int'(a_it), 1);
    chk("a_protocol", proto_err, 0);
    chk("a_candidates", cand_cnt, 1024);
    chk("b_done_cycle", db_cyc, 5636);
    chk("b_done_count", db_n, 1);
    chk("b_c1", int'({b_c1x, b_c1y}), 8'h59);
    chk("b_c2", int'({b_c2x, b_c2y}), 8'hff);
    chk("b_iter", int'(b_it), 0);

    // frame C: two clusters, START held high while busy
    for (int i = 0; i < 40; i++) begin
      px[i] = (i < 20) ? 2 : 12;
      py[i] = (i < 20) ? 2 : 12;
    end
    start_a = 1'b1;
    @(posedge CLK);
    da_cyc = -1; da_n = 0;
    for (int cyc = 1; cyc <= 11300; cyc++) begin
      @(negedge CLK);
      if (a_done) begin
        da_n++;
        if (da_cyc < 0) da_cyc = cyc;
        start_a = 1'b0;
      end
    end
    start_a = 1'b0;
    chk("c_done_cycle", da_cyc, 11271);
    chk("c_done_count", da_n, 1);
    chk("c_busy_after", int'(a_busy), 0);
    chk("c_c1", int'({a_c1x, a_c1y}), 8'hef);
    chk("c_c2", int'({a_c2x, a_c2y}), 8'h26);
    chk("c_iter", int'(a_it), 1);
    bad = 0;
    for (int i = 0; i < 40; i++)
      if (covers(px[i], py[i], int'(a_c1x), int'(a_c1y)) ||
          covers(px[i], py[i], int'(a_c2x), int'(a_c2y)))
        bad++;
    chk("c_hit_sum", bad, 40);

    // reset asserted in the middle of a CALC burst
    start_a = 1'b1;
    @(posedge CLK);
    for (int cyc = 1; cyc <= 50; cyc++) begin
      @(negedge CLK);
      start_a = 1'b0;
    end
    chk("r_calc_before", int'(a_calc), 1);
    #2 RST_N = 1'b0;
    #1;
    chk("r_busy", int'(a_busy), 0);
    chk("r_done", int'(a_done), 0);
    chk("r_calc", int'(a_calc), 0);
    chk("r_addr_scan", int'({a_addr, a_sx, a_sy}), 0);
    chk("r_res", int'({a_c1x, a_c1y, a_c2x, a_c2y, a_it}), 0);
    @(negedge CLK);
    RST_N = 1'b1;
    bad = 0;
    repeat (20) begin
      @(negedge CLK);
      if (a_busy || a_done) bad++;
    end
    chk("r_stays_idle", bad, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
